cdc_req_arbiter: RTL and testbench

//  Collects N four-phase request/acknowledge handshakes that originate in the slow clock domain.

---
 rtl/cdc_req_arbiter.sv | 91 +++++++++
 tb/tb_cdc_req_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cdc_req_arbiter.sv
// cdc_req_arbiter: synchronises slow-domain four-phase requests and grants a shared fast-domain resource round-robin
module cdc_req_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk_fast,
  input  logic           rst_n,
  input  logic [N-1:0]   req_slow,
  output logic [N-1:0]   ack_fast,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  input  logic           gnt_ready,
  input  logic           svc_done,
  output logic           busy
);
  localparam int W = $clog2(N);
  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;
  state_t state, state_d;
  logic [N-1:0] s1, s2, s3, pending, pending_d, ack_d, rise, clr;
  logic [W-1:0] rr_ptr, rr_ptr_d, gid, gid_d, sel, idx;
  logic found, gnt_valid_d, busy_d;
  assign rise   = s2 & ~s3 & ~ack_fast;
  assign gnt_id = IDW'(gid);
  // first pending bit at or after rr_ptr, wrapping modulo N
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int j = 0; j < N; j++) begin
      idx = W'((int'(rr_ptr) + j) % N);
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end
  always_comb begin
    state_d     = state;
    gnt_valid_d = gnt_valid;
    busy_d      = busy;
    gid_d       = gid;
    rr_ptr_d    = rr_ptr;
    clr         = '0;
    unique case (state)
      IDLE: if (found) begin
        state_d     = GRANT;
        gnt_valid_d = 1'b1;
        gid_d       = sel;
      end
      GRANT: if (gnt_ready) begin
        state_d     = BUSY;
        gnt_valid_d = 1'b0;
        busy_d      = 1'b1;
      end
      BUSY: if (svc_done) begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        clr      = N'(1) << gid;
        rr_ptr_d = (gid == W'(N - 1)) ? '0 : gid + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending | rise) & ~clr;
    ack_d     = (ack_fast & s2) | clr;
  end
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      state     <= IDLE;
      pending   <= '0;
      ack_fast  <= '0;
      gnt_valid <= 1'b0;
      busy      <= 1'b0;
      gid       <= '0;
      rr_ptr    <= '0;
    end else begin
      s1        <= req_slow;
      s2        <= s1;
      s3        <= s2;
      state     <= state_d;
      pending   <= pending_d;
      ack_fast  <= ack_d;
      gnt_valid <= gnt_valid_d;
      busy      <= busy_d;
      gid       <= gid_d;
      rr_ptr    <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_cdc_req_arbiter.sv
// tb_cdc_req_arbiter: directed bench with a grant-order scoreboard queue and immediate-assertion checks
module tb_cdc_req_arbiter;
  logic       clk_fast = 1'b0;
  logic       rst_n;
  logic [3:0] req_slow;
  logic [3:0] ack_fast;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       gnt_ready;
  logic       svc_done;
  logic       busy;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int ids[3] = '{0, 1, 3};

  cdc_req_arbiter #(.N(4), .IDW(2)) dut (
    .clk_fast(clk_fast), .rst_n(rst_n), .req_slow(req_slow), .ack_fast(ack_fast),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_ready(gnt_ready),
    .svc_done(svc_done), .busy(busy)
  );

  always #5 clk_fast = ~clk_fast;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_fast);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant();
    int n = 0;
    int e;
    while (gnt_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 99;
    chk("gnt_valid", {31'b0, gnt_valid}, 1);
    chk("gnt_id", {30'b0, gnt_id}, e);
  endtask

  task automatic serve(input int id);
    gnt_ready = 1'b1;
    tick();
    chk("busy_set", {31'b0, busy}, 1);
    chk("gv_drop", {31'b0, gnt_valid}, 0);
    gnt_ready = 1'b0;
    tick();
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    chk("busy_clr", {31'b0, busy}, 0);
    chk("ack_set", {31'b0, ack_fast[id]}, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ack", {28'b0, ack_fast}, 0);
    chk("rst_gv", {31'b0, gnt_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    req_slow  = '0;
    gnt_ready = 1'b0;
    svc_done  = 1'b0;
    do_reset();
    // single request: grant lands three edges after the first sampling edge
    req_slow = 4'b0100;
    exp_q.push_back(2);
    repeat (3) tick();
    chk("lat_early", {31'b0, gnt_valid}, 0);
    tick();
    chk("lat_grant", {31'b0, gnt_valid}, 1);
    wait_grant();
    serve(2);
    req_slow = 4'b0000;
    tick();
    tick();
    chk("ack_hold", {28'b0, ack_fast}, 4'b0100);
    tick();
    chk("ack_release", {28'b0, ack_fast}, 0);
    // round robin from rr_ptr=0
    do_reset();
    req_slow = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        chk("idle_gap", {31'b0, gnt_valid}, 0);
        tick();
        chk("regrant", {31'b0, gnt_valid}, 1);
      end
      wait_grant();
      serve(i);
    end
    chk("ack_all", {28'b0, ack_fast}, 4'b1111);
    req_slow = 4'b0000;
    repeat (4) tick();
    chk("ack_all_clr", {28'b0, ack_fast}, 0);
    req_slow = 4'b1001;
    exp_q.push_back(0);
    exp_q.push_back(3);
    wait_grant();
    serve(0);
    wait_grant();
    serve(3);
    // back-pressure with a late arrival on another channel
    req_slow = 4'b0000;
    repeat (4) tick();
    chk("bp_pre_ack", {28'b0, ack_fast}, 0);
    req_slow = 4'b0100;
    exp_q.push_back(2);
    wait_grant();
    req_slow = 4'b0110;
    exp_q.push_back(1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", {31'b0, gnt_valid}, 1);
      chk("bp_id", {30'b0, gnt_id}, 2);
    end
    serve(2);
    tick();
    chk("bp_regrant", {31'b0, gnt_valid}, 1);
    wait_grant();
    serve(1);
    // stray handshake inputs while idle
    req_slow = 4'b0000;
    repeat (4) tick();
    svc_done  = 1'b1;
    gnt_ready = 1'b1;
    tick();
    svc_done  = 1'b0;
    gnt_ready = 1'b0;
    repeat (3) tick();
    chk("stray_gv", {31'b0, gnt_valid}, 0);
    chk("stray_busy", {31'b0, busy}, 0);
    chk("stray_ack", {28'b0, ack_fast}, 0);
    // request glitch timed so its re-rise is seen while ack is high
    req_slow = 4'b0001;
    exp_q.push_back(0);
    wait_grant();
    gnt_ready = 1'b1;
    tick();
    chk("pv_busy", {31'b0, busy}, 1);
    gnt_ready = 1'b0;
    req_slow  = 4'b0000;
    tick();
    req_slow = 4'b0001;
    tick();
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    chk("pv_done", {31'b0, busy}, 0);
    chk("pv_ack", {28'b0, ack_fast}, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("pv_no_grant", {31'b0, gnt_valid}, 0);
    end
    chk("pv_ack_hold", {28'b0, ack_fast}, 4'b0001);
    // asynchronous reset while busy
    req_slow = 4'b1011;
    exp_q.push_back(1);
    wait_grant();
    gnt_ready = 1'b1;
    tick();
    chk("mid_busy", {31'b0, busy}, 1);
    gnt_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_busy", {31'b0, busy}, 0);
    chk("async_gv", {31'b0, gnt_valid}, 0);
    chk("async_ack", {28'b0, ack_fast}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(ids[i]);
    for (int i = 0; i < 3; i++) begin
      wait_grant();
      serve(ids[i]);
    end
    chk("q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
